// File: rtl/ram_arb_pkg.sv
// Shared types for the RAM arbiter: FSM states, requester IDs, CPU ROM page constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        VID  = 2'd1,
        CPU  = 2'd2
    } req_id_t;

    // CPU pages (cpu_a[22:14]) that return real data when ROM masking is on:
    // the whole lower half (top page bit clear) plus two extra pages.
    localparam logic       ROM_LOW_HALF_BIT = 1'b0;
    localparam logic [8:0] ROM_PAGE_A       = 9'h100;
    localparam logic [8:0] ROM_PAGE_B       = 9'h107;

    function automatic logic cpu_page_visible(input logic [22:0] addr);
        logic [8:0] page;
        page = addr[22:14];
        return (page[8] == ROM_LOW_HALF_BIT) || (page == ROM_PAGE_A) || (page == ROM_PAGE_B);
    endfunction

endpackage

// File: rtl/ram_arb_select.sv
// Winner selection: boot > video > CPU, with CPU promoted over video after CPU_STARVE_MAX video grants.
// Latency: combinational winner; the starvation counter updates on the grant edge.
// Backpressure: grants only when grant_i is asserted by the FSM; requests are level and simply wait.
module ram_arb_select
    import ram_arb_pkg::*;
#(
    parameter int unsigned CPU_STARVE_MAX = 3
) (
    input  logic    clk_sys,
    input  logic    reset,
    input  logic    boot_req_i,
    input  logic    vid_req_i,
    input  logic    cpu_req_i,
    input  logic    grant_i,
    output logic    win_vld_o,
    output req_id_t win_id_o
);

    localparam int unsigned       CNT_W      = $clog2(CPU_STARVE_MAX + 2);
    localparam logic [CNT_W-1:0]  STARVE_LIM = CNT_W'(CPU_STARVE_MAX);

    logic [CNT_W-1:0] starve_q;
    logic [CNT_W-1:0] starve_d;
    logic             starve_hit;

    assign starve_hit = (starve_q >= STARVE_LIM);

    // Pick the winner from the current request levels and the starvation state.
    always_comb begin
        win_vld_o = boot_req_i | vid_req_i | cpu_req_i;
        win_id_o  = BOOT;
        if (boot_req_i) begin
            win_id_o = BOOT;
        end else if (cpu_req_i && (starve_hit || !vid_req_i)) begin
            win_id_o = CPU;
        end else if (vid_req_i) begin
            win_id_o = VID;
        end
    end

    // Count video grants taken while the CPU waits; any CPU grant clears the count.
    always_comb begin
        starve_d = starve_q;
        if (grant_i) begin
            if (win_id_o == CPU) begin
                starve_d = '0;
            end else if ((win_id_o == VID) && cpu_req_i && !starve_hit) begin
                starve_d = starve_q + CNT_W'(1);
            end
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Three-way (boot/video/CPU) arbiter onto a single-port RAM; optional CPU ROM-page masking via RAM_ARB_ROMMASK_EN.
// Latency: IDLE->ISSUE->WAIT->DONE, 4 cycles IDLE-to-IDLE with a 1-cycle mem_ack.
// Backpressure: requesters hold level requests until their ack pulse; WAIT stretches until mem_ack.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned CPU_STARVE_MAX = 3,
    parameter logic [6:0]  VID_PAGE       = 7'h02
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        boot_req,
    input  logic [22:0] boot_a,
    input  logic [7:0]  boot_d,
    output logic        boot_ack,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [22:0] cpu_a,
    input  logic [7:0]  cpu_din,
    output logic [7:0]  cpu_dout,
    output logic        cpu_ack,
    input  logic        vid_req,
    input  logic [15:0] vid_a,
    output logic [7:0]  vid_dout,
    output logic        vid_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic [22:0] mem_a,
    output logic [7:0]  mem_din,
    input  logic [7:0]  mem_dout,
    input  logic        mem_ack
);

    arb_state_t  state_q;
    arb_state_t  state_d;
    req_id_t     win_q;
    logic        we_q;
    logic [22:0] addr_q;
    logic [7:0]  din_q;
    logic [7:0]  cpu_dout_q;
    logic [7:0]  vid_dout_q;

    logic        sel_vld;
    req_id_t     sel_id;
    logic        grant;
    logic        rd_done;
    logic [7:0]  cpu_rd_data;

    assign grant   = (state_q == ST_IDLE) && sel_vld;
    assign rd_done = (state_q == ST_WAIT) && mem_ack && !we_q;

    ram_arb_select #(
        .CPU_STARVE_MAX (CPU_STARVE_MAX)
    ) u_select (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .boot_req_i (boot_req),
        .vid_req_i  (vid_req),
        .cpu_req_i  (cpu_rd | cpu_wr),
        .grant_i    (grant),
        .win_vld_o  (sel_vld),
        .win_id_o   (sel_id)
    );

`ifdef RAM_ARB_ROMMASK_EN
    assign cpu_rd_data = cpu_page_visible(addr_q) ? mem_dout : 8'hFF;
`else
    assign cpu_rd_data = mem_dout;
`endif

    // State register.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: one issue cycle, wait for the memory, one ack cycle, back to arbitration.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (sel_vld) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (mem_ack) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from state: single-cycle mem_req and per-requester ack pulses.
    always_comb begin
        mem_req  = (state_q == ST_ISSUE);
        boot_ack = (state_q == ST_DONE) && (win_q == BOOT);
        vid_ack  = (state_q == ST_DONE) && (win_q == VID);
        cpu_ack  = (state_q == ST_DONE) && (win_q == CPU);
    end

    // Latch the winner's command at grant; it stays on the memory bus until the next grant.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            win_q  <= BOOT;
            we_q   <= 1'b0;
            addr_q <= '0;
            din_q  <= '0;
        end else if (grant) begin
            win_q <= sel_id;
            case (sel_id)
                BOOT: begin
                    we_q   <= 1'b1;
                    addr_q <= boot_a;
                    din_q  <= boot_d;
                end
                VID: begin
                    we_q   <= 1'b0;
                    addr_q <= {VID_PAGE, vid_a};
                    din_q  <= '0;
                end
                default: begin
                    // rd+wr together counts as a write
                    we_q   <= cpu_wr;
                    addr_q <= cpu_a;
                    din_q  <= cpu_din;
                end
            endcase
        end
    end

    // Capture read data for the winning channel; each dout holds until that channel's next read.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cpu_dout_q <= 8'hFF;
            vid_dout_q <= 8'hFF;
        end else if (rd_done) begin
            if (win_q == VID) begin
                vid_dout_q <= mem_dout;
            end else if (win_q == CPU) begin
                cpu_dout_q <= cpu_rd_data;
            end
        end
    end

    assign mem_we   = we_q;
    assign mem_a    = addr_q;
    assign mem_din  = din_q;
    assign cpu_dout = cpu_dout_q;
    assign vid_dout = vid_dout_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed vector table, corner sequences, randomized traffic vs. a transaction model.
// Latency: memory responder acks 1..3 cycles after mem_req.
// Backpressure: requesters hold until their ack, then drop.
module tb_ram_arbiter;

    localparam int STARVE_MAX = 3;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic        boot_req = 1'b0;
    logic [22:0] boot_a   = '0;
    logic [7:0]  boot_d   = '0;
    logic        cpu_rd   = 1'b0;
    logic        cpu_wr   = 1'b0;
    logic [22:0] cpu_a    = '0;
    logic [7:0]  cpu_din  = '0;
    logic        vid_req  = 1'b0;
    logic [15:0] vid_a    = '0;
    logic [7:0]  mem_dout = '0;
    logic        mem_ack  = 1'b0;
    logic        boot_ack, cpu_ack, vid_ack, mem_req, mem_we;
    logic [7:0]  cpu_dout, vid_dout, mem_din;
    logic [22:0] mem_a;

    ram_arbiter dut (
        .clk_sys (clk_sys), .reset (reset),
        .boot_req (boot_req), .boot_a (boot_a), .boot_d (boot_d), .boot_ack (boot_ack),
        .cpu_rd (cpu_rd), .cpu_wr (cpu_wr), .cpu_a (cpu_a), .cpu_din (cpu_din),
        .cpu_dout (cpu_dout), .cpu_ack (cpu_ack),
        .vid_req (vid_req), .vid_a (vid_a), .vid_dout (vid_dout), .vid_ack (vid_ack),
        .mem_req (mem_req), .mem_we (mem_we), .mem_a (mem_a), .mem_din (mem_din),
        .mem_dout (mem_dout), .mem_ack (mem_ack)
    );

    always #5 clk_sys = ~clk_sys;

    int cmp_cnt = 0;
    int err_cnt = 0;

    // memory responder controls
    bit          resp_en    = 1'b1;
    bit          use_hash   = 1'b0;
    bit          rand_lat   = 1'b0;
    int          mem_lat    = 1;
    logic [7:0]  resp_dat   = '0;
    bit          inject_ack = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] mem_fn(input logic [22:0] a);
        return a[7:0] ^ a[15:8] ^ {1'b0, a[22:16]} ^ 8'h3C;
    endfunction

    // What the CPU should see for read data d at address a.
    function automatic logic [7:0] cpu_view(input logic [22:0] a, input logic [7:0] d);
`ifdef RAM_ARB_ROMMASK_EN
        int page;
        page = int'(a >> 14);
        if (page < 256 || page == 256 || page == 263) return d;
        return 8'hFF;
`else
        return d;
`endif
    endfunction

    function automatic int ack_id();
        if (boot_ack) return 0;
        if (vid_ack)  return 1;
        if (cpu_ack)  return 2;
        return -1;
    endfunction

    // Single-port memory model: one-cycle mem_ack pulse after the chosen latency.
    initial begin
        forever begin
            int          lat;
            logic [22:0] a;
            @(negedge clk_sys);
            if (inject_ack) begin
                inject_ack = 1'b0;
                mem_ack  = 1'b1;
                mem_dout = 8'h99;
                @(negedge clk_sys);
                mem_ack = 1'b0;
            end else if (resp_en && mem_req) begin
                lat = rand_lat ? int'($urandom_range(1, 3)) : mem_lat;
                a   = mem_a;
                repeat (lat) @(negedge clk_sys);
                mem_ack  = 1'b1;
                mem_dout = use_hash ? mem_fn(a) : resp_dat;
                @(negedge clk_sys);
                mem_ack = 1'b0;
            end
        end
    end

    // Transaction-level reference for the random phase.
    bit          mon_on = 1'b0;
    int          starve = 0;
    int          n_txn  = 0;
    int          exp_win = -1;
    bit          exp_rd  = 1'b0;
    logic [7:0]  exp_dat = '0;
    bit          s_boot = 1'b0, s_vid = 1'b0, s_rd = 1'b0, s_wr = 1'b0;
    logic [22:0] s_ba = '0, s_ca = '0;
    logic [7:0]  s_bd = '0, s_cd = '0;
    logic [15:0] s_va = '0;

    initial begin
        forever begin
            bit          p_we;
            logic [22:0] p_a;
            logic [7:0]  p_din;
            @(negedge clk_sys);
            if (mon_on) begin
                if (mem_req) begin
                    // requests as they stood during the arbitration cycle
                    exp_rd = 1'b0;
                    if (s_boot) begin
                        exp_win = 0; p_we = 1'b1; p_a = s_ba; p_din = s_bd;
                    end else if ((s_rd || s_wr) && (starve == STARVE_MAX || !s_vid)) begin
                        exp_win = 2; p_we = s_wr; p_a = s_ca; p_din = s_cd;
                        starve = 0;
                        exp_rd  = !s_wr;
                        exp_dat = cpu_view(s_ca, mem_fn(s_ca));
                    end else if (s_vid) begin
                        exp_win = 1; p_we = 1'b0; p_a = {7'h02, s_va}; p_din = 8'h00;
                        if (s_rd || s_wr) starve = starve + 1;
                        exp_rd  = 1'b1;
                        exp_dat = mem_fn({7'h02, s_va});
                    end else begin
                        exp_win = -1; p_we = 1'b0; p_a = '0; p_din = '0;
                        chk("rnd_unrequested_mem_req", 32'(mem_req), 32'(1'b0));
                    end
                    chk("rnd_mem_we", 32'(mem_we), 32'(p_we));
                    chk("rnd_mem_a", 32'(mem_a), 32'(p_a));
                    chk("rnd_mem_din", 32'(mem_din), 32'(p_din));
                end
                if (boot_ack || vid_ack || cpu_ack) begin
                    chk("rnd_ack_owner", 32'(ack_id()), 32'(exp_win));
                    if (exp_rd && exp_win == 1) chk("rnd_vid_dout", 32'(vid_dout), 32'(exp_dat));
                    if (exp_rd && exp_win == 2) chk("rnd_cpu_dout", 32'(cpu_dout), 32'(exp_dat));
                    n_txn++;
                end
            end
            s_boot = boot_req; s_vid = vid_req; s_rd = cpu_rd; s_wr = cpu_wr;
            s_ba = boot_a; s_bd = boot_d; s_va = vid_a; s_ca = cpu_a; s_cd = cpu_din;
        end
    end

    // Directed vectors: one transaction each from idle.
    typedef struct {
        bit          boot, vid, rd, wr;
        logic [22:0] ba;  logic [7:0] bd;
        logic [15:0] va;
        logic [22:0] ca;  logic [7:0] cd;
        logic [7:0]  dat; int lat;
        bit          ewe; logic [22:0] ea; logic [7:0] edin;
        logic [2:0]  eack;               // {boot, vid, cpu}
        logic [7:0]  ecpu, evid;
    } vec_t;

    vec_t vt[10];

    task automatic drop_all();
        boot_req = 1'b0; vid_req = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk_sys); #1;
        drop_all();
        reset = 1'b1;
        repeat (2) @(posedge clk_sys);
        #1 reset = 1'b0;
    endtask

    task automatic run_vec(input int i);
        int n;
        bit seen;
        @(posedge clk_sys); #1;
        resp_dat = vt[i].dat; mem_lat = vt[i].lat;
        boot_req = vt[i].boot; boot_a = vt[i].ba; boot_d = vt[i].bd;
        vid_req = vt[i].vid; vid_a = vt[i].va;
        cpu_rd = vt[i].rd; cpu_wr = vt[i].wr; cpu_a = vt[i].ca; cpu_din = vt[i].cd;
        n = 0; seen = 1'b0;
        while (!seen && n < 30) begin
            @(negedge clk_sys);
            if (mem_req) seen = 1'b1; else n++;
        end
        chk($sformatf("v%0d_mem_req_seen", i), 32'(seen), 32'(1'b1));
        chk($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(vt[i].ewe));
        chk($sformatf("v%0d_mem_a", i), 32'(mem_a), 32'(vt[i].ea));
        chk($sformatf("v%0d_mem_din", i), 32'(mem_din), 32'(vt[i].edin));
        n = 0; seen = 1'b0;
        while (!seen && n < 30) begin
            @(negedge clk_sys);
            if (boot_ack || vid_ack || cpu_ack) seen = 1'b1; else n++;
        end
        chk($sformatf("v%0d_acks", i), 32'({boot_ack, vid_ack, cpu_ack}), 32'(vt[i].eack));
        chk($sformatf("v%0d_cpu_dout", i), 32'(cpu_dout), 32'(vt[i].ecpu));
        chk($sformatf("v%0d_vid_dout", i), 32'(vid_dout), 32'(vt[i].evid));
        @(posedge clk_sys); #1;
        drop_all();
        // losing requests were never latched, so nothing else may run
        n = 0;
        repeat (6) begin
            @(negedge clk_sys);
            if (mem_req || boot_ack || vid_ack || cpu_ack) n++;
        end
        chk($sformatf("v%0d_no_extra_txn", i), 32'(n), 32'(0));
    endtask

    // Video and CPU both held: VID,VID,VID,CPU repeating, back-to-back every 4 cycles.
    task automatic seq_starve();
        int ids[$];
        int cycs[$];
        int exp_ord[8] = '{1, 1, 1, 2, 1, 1, 1, 2};
        int cyc = 0;
        do_reset();
        mem_lat = 1; resp_dat = 8'h00;
        vid_req = 1'b1; vid_a = 16'h0040;
        cpu_rd = 1'b1; cpu_a = 23'h000100;
        while (ids.size() < 8 && cyc < 200) begin
            @(negedge clk_sys);
            cyc++;
            if (ack_id() >= 0) begin
                ids.push_back(ack_id());
                cycs.push_back(cyc);
            end
        end
        @(posedge clk_sys); #1;
        drop_all();
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("starve_order_%0d", k), 32'((k < ids.size()) ? ids[k] : -1), 32'(exp_ord[k]));
        end
        for (int k = 1; k < 8; k++) begin
            chk($sformatf("turnaround_%0d", k),
                32'((k < cycs.size()) ? cycs[k] - cycs[k-1] : -1), 32'(4));
        end
        repeat (6) @(negedge clk_sys);
    endtask

    // Boot raised while a CPU read is in WAIT: CPU finishes, then boot, then video.
    task automatic seq_boot_during_cpu();
        int          ids[$];
        logic [22:0] as[$];
        bit          wes[$];
        int          n = 0;
        bit          seen = 1'b0;
        int          id;
        mem_lat = 3; resp_dat = 8'h44;
        @(posedge clk_sys); #1;
        cpu_rd = 1'b1; cpu_a = 23'h000200;
        while (!seen && n < 30) begin
            @(negedge clk_sys);
            if (mem_req) seen = 1'b1; else n++;
        end
        @(posedge clk_sys); #1;
        boot_req = 1'b1; boot_a = 23'h000300; boot_d = 8'h66;
        vid_req = 1'b1; vid_a = 16'h0007;
        for (int k = 0; k < 80 && ids.size() < 3; k++) begin
            @(negedge clk_sys);
            if (mem_req) begin
                as.push_back(mem_a);
                wes.push_back(mem_we);
            end
            id = ack_id();
            if (id >= 0) begin
                ids.push_back(id);
                @(posedge clk_sys); #1;
                if (id == 0) boot_req = 1'b0;
                if (id == 1) vid_req = 1'b0;
                if (id == 2) begin cpu_rd = 1'b0; cpu_wr = 1'b0; end
            end
        end
        drop_all();
        chk("bootwait_ack0", 32'((ids.size() > 0) ? ids[0] : -1), 32'(2));
        chk("bootwait_ack1", 32'((ids.size() > 1) ? ids[1] : -1), 32'(0));
        chk("bootwait_ack2", 32'((ids.size() > 2) ? ids[2] : -1), 32'(1));
        chk("bootwait_boot_a", 32'((as.size() > 0) ? as[0] : 23'h7FFFFF), 32'(23'h000300));
        chk("bootwait_boot_we", 32'((wes.size() > 0) ? wes[0] : 1'b0), 32'(1'b1));
        chk("bootwait_vid_a", 32'((as.size() > 1) ? as[1] : 23'h7FFFFF), 32'(23'h020007));
        chk("bootwait_cpu_dout", 32'(cpu_dout), 32'(cpu_view(23'h000200, 8'h44)));
        repeat (6) @(negedge clk_sys);
    endtask

    // Reset while in WAIT, memory ack arrives afterwards: no ack, clean idle, next request works.
    task automatic seq_reset_in_wait();
        int n = 0;
        bit seen = 1'b0;
        resp_en = 1'b0;
        @(posedge clk_sys); #1;
        cpu_rd = 1'b1; cpu_a = 23'h000400;
        while (!seen && n < 30) begin
            @(negedge clk_sys);
            if (mem_req) seen = 1'b1; else n++;
        end
        chk("rstwait_mem_req_seen", 32'(seen), 32'(1'b1));
        @(posedge clk_sys); #1;           // now in WAIT
        reset = 1'b1;
        cpu_rd = 1'b0;
        @(posedge clk_sys); #1;           // reset taken
        reset = 1'b0;
        inject_ack = 1'b1;
        n = 0;
        repeat (6) begin
            @(negedge clk_sys);
            if (mem_req || boot_ack || vid_ack || cpu_ack) n++;
        end
        chk("rstwait_no_activity", 32'(n), 32'(0));
        chk("rstwait_acks", 32'({boot_ack, vid_ack, cpu_ack}), 32'(0));
        chk("rstwait_cpu_dout", 32'(cpu_dout), 32'(8'hFF));
        chk("rstwait_mem_a", 32'(mem_a), 32'(0));
        resp_en = 1'b1; mem_lat = 1; resp_dat = 8'h5C;
        @(posedge clk_sys); #1;
        cpu_rd = 1'b1; cpu_a = 23'h000400;
        n = 0; seen = 1'b0;
        while (!seen && n < 30) begin
            @(negedge clk_sys);
            if (cpu_ack) seen = 1'b1; else n++;
        end
        chk("rstwait_recover_ack", 32'(seen), 32'(1'b1));
        chk("rstwait_recover_dout", 32'(cpu_dout), 32'(cpu_view(23'h000400, 8'h5C)));
        @(posedge clk_sys); #1;
        drop_all();
        repeat (4) @(negedge clk_sys);
    endtask

    // Randomized traffic; the monitor process does the checking.
    task automatic seq_random();
        int r;
        do_reset();
        use_hash = 1'b1; rand_lat = 1'b1;
        starve = 0; n_txn = 0;
        @(negedge clk_sys);
        mon_on = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk_sys); #1;
            if (boot_req && boot_ack) boot_req = 1'b0;
            else if (!boot_req && $urandom_range(0, 31) == 0) begin
                boot_req = 1'b1; boot_a = 23'($urandom); boot_d = 8'($urandom);
            end
            if (vid_req && vid_ack) vid_req = 1'b0;
            else if (!vid_req && $urandom_range(0, 2) == 0) begin
                vid_req = 1'b1; vid_a = 16'($urandom);
            end
            if ((cpu_rd || cpu_wr) && cpu_ack) begin
                cpu_rd = 1'b0; cpu_wr = 1'b0;
            end else if (!(cpu_rd || cpu_wr) && $urandom_range(0, 2) == 0) begin
                r = int'($urandom_range(0, 3));
                cpu_rd = (r != 1); cpu_wr = (r == 1 || r == 2);
                cpu_a = 23'($urandom); cpu_din = 8'($urandom);
            end
        end
        for (int c = 0; c < 200 && (boot_req || vid_req || cpu_rd || cpu_wr); c++) begin
            @(posedge clk_sys); #1;
            if (boot_ack) boot_req = 1'b0;
            if (vid_ack) vid_req = 1'b0;
            if (cpu_ack) begin cpu_rd = 1'b0; cpu_wr = 1'b0; end
        end
        chk("rnd_drained", 32'({boot_req, vid_req, cpu_rd, cpu_wr}), 32'(0));
        repeat (8) @(negedge clk_sys);
        mon_on = 1'b0;
        chk("rnd_enough_txns", 32'(n_txn >= 100), 32'(1'b1));
        use_hash = 1'b0; rand_lat = 1'b0;
    endtask

    initial begin
        vt[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 23'h004000, 8'h5A, 16'h0000, 23'h000000, 8'h00, 8'h00, 2,
                  1'b1, 23'h004000, 8'h5A, 3'b100, 8'hFF, 8'hFF};
        vt[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 23'h000000, 8'h00, 16'h1234, 23'h000000, 8'h00, 8'hC3, 1,
                  1'b0, 23'h021234, 8'h00, 3'b010, 8'hFF, 8'hC3};
        vt[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 23'h000000, 8'h00, 16'h0000, 23'h1C0000, 8'h00, 8'h12, 1,
                  1'b0, 23'h1C0000, 8'h00, 3'b001, cpu_view(23'h1C0000, 8'h12), 8'hC3};
        vt[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 23'h000000, 8'h00, 16'h0000, 23'h000010, 8'hA5, 8'h00, 1,
                  1'b1, 23'h000010, 8'hA5, 3'b001, cpu_view(23'h1C0000, 8'h12), 8'hC3};
        vt[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 23'h000020, 8'h11, 16'h0005, 23'h000030, 8'h00, 8'h00, 3,
                  1'b1, 23'h000020, 8'h11, 3'b100, cpu_view(23'h1C0000, 8'h12), 8'hC3};
        vt[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 23'h000000, 8'h00, 16'h0001, 23'h000030, 8'h00, 8'h77, 1,
                  1'b0, 23'h020001, 8'h00, 3'b010, cpu_view(23'h1C0000, 8'h12), 8'h77};
        vt[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 23'h000000, 8'h00, 16'h0000, 23'h7FFFFF, 8'h00, 8'h00, 1,
                  1'b1, 23'h7FFFFF, 8'h00, 3'b001, cpu_view(23'h1C0000, 8'h12), 8'h77};
        vt[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 23'h000000, 8'h00, 16'hFFFF, 23'h000000, 8'h00, 8'h00, 1,
                  1'b0, 23'h02FFFF, 8'h00, 3'b010, cpu_view(23'h1C0000, 8'h12), 8'h00};
        vt[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 23'h000000, 8'h00, 16'h0000, 23'h600000, 8'h00, 8'h9E, 1,
                  1'b0, 23'h600000, 8'h00, 3'b001, cpu_view(23'h600000, 8'h9E), 8'h00};
        vt[9] = '{1'b0, 1'b0, 1'b1, 1'b0, 23'h000000, 8'h00, 16'h0000, 23'h41C000, 8'h00, 8'h3B, 1,
                  1'b0, 23'h41C000, 8'h00, 3'b001, cpu_view(23'h41C000, 8'h3B), 8'h00};

        // reset state
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        chk("rst_ctrl_outs", 32'({mem_req, mem_we, boot_ack, vid_ack, cpu_ack}), 32'(0));
        chk("rst_mem_a", 32'(mem_a), 32'(0));
        chk("rst_mem_din", 32'(mem_din), 32'(0));
        chk("rst_cpu_dout", 32'(cpu_dout), 32'(8'hFF));
        chk("rst_vid_dout", 32'(vid_dout), 32'(8'hFF));
        @(posedge clk_sys); #1 reset = 1'b0;
        repeat (2) @(negedge clk_sys);
        chk("post_rst_idle", 32'({mem_req, boot_ack, vid_ack, cpu_ack}), 32'(0));

        for (int i = 0; i < 10; i++) run_vec(i);
        seq_starve();
        seq_boot_during_cpu();
        seq_reset_in_wait();
        seq_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d mismatched=%0d", cmp_cnt, err_cnt);
        $fatal(1);
    end

endmodule
